fc_adder_tree_acc: RTL and testbench



---
 rtl/fc_adder_tree_acc_if.sv | 33 +++
 rtl/fc_adder_tree_acc.sv | 162 ++++++++++++++++
 tb/tb_fc_adder_tree_acc.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/fc_adder_tree_acc_if.sv
// Bus bundle for the FC adder tree accumulator.
// master: producer side (drives enable, beat valid/last and operands, receives packet sums)
// slave : the adder tree itself
//   i_en     pipeline advance
//   i_valid  i_data carries a real beat
//   i_last   final beat of the packet (qualified by i_valid)
//   i_data   IDIM operands of IWID bits
//   o_valid  one-cycle pulse marking a new packet sum
//   o_data   packet sum, held between pulses
//   o_ovf    packet ran longer than the accumulator was sized for
interface fc_adder_tree_acc_if #(
  parameter int unsigned IDIM = 64,
  parameter int unsigned IWID = 10,
  parameter int unsigned OWID = 22
);
  logic                       i_en;
  logic                       i_valid;
  logic                       i_last;
  logic [IDIM-1:0][IWID-1:0]  i_data;
  logic                       o_valid;
  logic [OWID-1:0]            o_data;
  logic                       o_ovf;

  modport master (
    output i_en, i_valid, i_last, i_data,
    input  o_valid, o_data, o_ovf
  );

  modport slave (
    input  i_en, i_valid, i_last, i_data,
    output o_valid, o_data, o_ovf
  );
endinterface

// File: rtl/fc_adder_tree_acc.sv
// Pipelined reduction adder tree with a packet accumulator.
// Each enabled beat reduces IDIM operands to one OWID-bit sum; sums of a
// multi-beat packet are accumulated and emitted on the last beat.
//   clk  clock
//   rst  synchronous active-high reset, overrides bus.i_en
//   bus  slave side of fc_adder_tree_acc_if (i_en/i_valid/i_last/i_data in,
//        o_valid/o_data/o_ovf out)
module fc_adder_tree_acc #(
  parameter int unsigned IDIM   = 64,
  parameter int unsigned IWID   = 10,
  parameter int unsigned SIGNED = 0,
  parameter int unsigned BDEP   = 2,
  parameter int unsigned ACCL2  = 6,
  parameter int unsigned IDL2   = $clog2(IDIM),
  parameter int unsigned OWID   = IWID + IDL2 + ACCL2
) (
  input  logic                 clk,
  input  logic                 rst,
  fc_adder_tree_acc_if.slave   bus
);

  localparam int unsigned NPAD = 1 << IDL2;
  localparam int unsigned NREG = IDL2 / BDEP;
  localparam int unsigned CW   = ACCL2 + 1;
  localparam logic [CW:0] LIMIT = (CW+1)'(2**ACCL2);

  // Operand extension to OWID; padding slots are zero.
  logic [NPAD-1:0][OWID-1:0] leaf;
  for (genvar j = 0; j < NPAD; j++) begin : g_leaf
    if (j < IDIM) begin : g_op
      if (SIGNED != 0) begin : g_sx
        assign leaf[j] = {{(OWID-IWID){bus.i_data[j][IWID-1]}}, bus.i_data[j]};
      end else begin : g_zx
        assign leaf[j] = OWID'(bus.i_data[j]);
      end
    end else begin : g_pad
      assign leaf[j] = '0;
    end
  end

  // Tree levels: pairwise adds, level k registered when k is a multiple of BDEP.
  for (genvar k = 1; k <= IDL2; k++) begin : g_lvl
    localparam int unsigned N = NPAD >> k;
    logic [2*N-1:0][OWID-1:0] src;
    logic [N-1:0][OWID-1:0]   sum_d;
    logic [N-1:0][OWID-1:0]   lvl;

    if (k == 1) begin : g_src0
      assign src = leaf;
    end else begin : g_srcn
      assign src = g_lvl[k-1].lvl;
    end

    for (genvar j = 0; j < N; j++) begin : g_add
      assign sum_d[j] = src[2*j] + src[2*j+1];
    end

    if (k % BDEP == 0) begin : g_reg
      logic [N-1:0][OWID-1:0] sum_q;
      always_ff @(posedge clk) begin
        if (rst)          sum_q <= '0;
        else if (bus.i_en) sum_q <= sum_d;
      end
      assign lvl = sum_q;
    end else begin : g_comb
      assign lvl = sum_d;
    end
  end

  logic [OWID-1:0] tree_sum;
  assign tree_sum = g_lvl[IDL2].lvl[0];

  // Valid/last sideband delayed to line up with the tree output.
  logic t_valid;
  logic t_last;
  if (NREG > 0) begin : g_sb
    logic [NREG-1:0] vld_q, vld_d, lst_q, lst_d;
    always_comb begin
      vld_d = vld_q;
      lst_d = lst_q;
      if (bus.i_en) begin
        vld_d = NREG'({vld_q, bus.i_valid});
        lst_d = NREG'({lst_q, bus.i_valid & bus.i_last});
      end
    end
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q <= '0;
        lst_q <= '0;
      end else begin
        vld_q <= vld_d;
        lst_q <= lst_d;
      end
    end
    assign t_valid = vld_q[NREG-1];
    assign t_last  = lst_q[NREG-1];
  end else begin : g_nosb
    assign t_valid = bus.i_valid;
    assign t_last  = bus.i_valid & bus.i_last;
  end

  // Accumulator, beat counter and packet output registers.
  logic [OWID-1:0] acc_q, acc_d, o_data_q, o_data_d, sum_c;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW:0]     cnt_inc;
  logic            beat_ovf_c;
  logic            ovf_seen_q, ovf_seen_d;
  logic            o_valid_q, o_valid_d, o_ovf_q, o_ovf_d;

  always_comb begin
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    ovf_seen_d = ovf_seen_q;
    o_valid_d  = o_valid_q;
    o_data_d   = o_data_q;
    o_ovf_d    = o_ovf_q;
    sum_c      = acc_q + tree_sum;
    cnt_inc    = {1'b0, cnt_q} + (CW+1)'(1);
    // Sticky flag keeps the overflow even if cnt later wraps within the packet.
    beat_ovf_c = cnt_inc > LIMIT;
    if (bus.i_en) begin
      o_valid_d = 1'b0;
      if (t_valid) begin
        if (t_last) begin
          o_data_d   = sum_c;
          o_valid_d  = 1'b1;
          o_ovf_d    = ovf_seen_q | beat_ovf_c;
          acc_d      = '0;
          cnt_d      = '0;
          ovf_seen_d = 1'b0;
        end else begin
          acc_d      = sum_c;
          cnt_d      = cnt_inc[CW-1:0];
          ovf_seen_d = ovf_seen_q | beat_ovf_c;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_seen_q <= 1'b0;
      o_valid_q  <= 1'b0;
      o_data_q   <= '0;
      o_ovf_q    <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      ovf_seen_q <= ovf_seen_d;
      o_valid_q  <= o_valid_d;
      o_data_q   <= o_data_d;
      o_ovf_q    <= o_ovf_d;
    end
  end

  assign bus.o_valid = o_valid_q;
  assign bus.o_data  = o_data_q;
  assign bus.o_ovf   = o_ovf_q;

endmodule

// File: tb/tb_fc_adder_tree_acc.sv
// Directed bench: three instances (unsigned, signed, small accumulator) of an
// 8 x 4-bit tree with one pipeline register, sharing control and reset.
module tb_fc_adder_tree_acc;

  typedef logic [7:0][3:0] vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  fc_adder_tree_acc_if #(.IDIM(8), .IWID(4), .OWID(13)) bu ();
  fc_adder_tree_acc_if #(.IDIM(8), .IWID(4), .OWID(13)) bs ();
  fc_adder_tree_acc_if #(.IDIM(8), .IWID(4), .OWID(8))  bo ();

  fc_adder_tree_acc #(.IDIM(8), .IWID(4), .SIGNED(0), .BDEP(2), .ACCL2(6))
    u_uns (.clk(clk), .rst(rst), .bus(bu.slave));
  fc_adder_tree_acc #(.IDIM(8), .IWID(4), .SIGNED(1), .BDEP(2), .ACCL2(6))
    u_sgn (.clk(clk), .rst(rst), .bus(bs.slave));
  fc_adder_tree_acc #(.IDIM(8), .IWID(4), .SIGNED(0), .BDEP(2), .ACCL2(1))
    u_ovf (.clk(clk), .rst(rst), .bus(bo.slave));

  function automatic vec_t fill(input logic [3:0] x);
    return {8{x}};
  endfunction

  task automatic drive(input logic en, input logic v, input logic l,
                       input vec_t du, input vec_t ds);
    bu.i_en = en; bu.i_valid = v; bu.i_last = l; bu.i_data = du;
    bo.i_en = en; bo.i_valid = v; bo.i_last = l; bo.i_data = du;
    bs.i_en = en; bs.i_valid = v; bs.i_last = l; bs.i_data = ds;
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, 1'b0, fill(4'h0), fill(4'h0));
  endtask

  task automatic beat(input logic l, input logic [3:0] x);
    drive(1'b1, 1'b1, l, fill(x), fill(x));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    vec_t mixed;
    mixed = {{4{4'h8}}, {4{4'h7}}};
    rst = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
    chk("rst_valid", 32'(bu.o_valid), 32'd0);
    chk("rst_data",  32'(bu.o_data),  32'd0);
    chk("rst_ovf",   32'(bu.o_ovf),   32'd0);

    // Single beat of 15s: pulse two cycles later.
    beat(1'b1, 4'hF); tick();
    idle();
    chk("one_c1_valid", 32'(bu.o_valid), 32'd0);
    tick();
    chk("one_c2_valid", 32'(bu.o_valid), 32'd1);
    chk("one_c2_data",  32'(bu.o_data),  32'd120);
    chk("one_c2_ovf",   32'(bu.o_ovf),   32'd0);
    tick();
    chk("one_c3_valid", 32'(bu.o_valid), 32'd0);
    chk("one_c3_hold",  32'(bu.o_data),  32'd120);

    // Three beats of 1s, then back-to-back single beat of 2s.
    beat(1'b0, 4'h1); tick();
    beat(1'b0, 4'h1); tick();
    beat(1'b1, 4'h1); tick();
    chk("three_c3_valid", 32'(bu.o_valid), 32'd0);
    beat(1'b1, 4'h2); tick();
    chk("three_c4_valid", 32'(bu.o_valid), 32'd1);
    chk("three_c4_data",  32'(bu.o_data),  32'd24);
    idle(); tick();
    chk("b2b_valid", 32'(bu.o_valid), 32'd1);
    chk("b2b_data",  32'(bu.o_data),  32'd16);
    tick();
    chk("b2b_end_valid", 32'(bu.o_valid), 32'd0);

    // Stall of 3 cycles plus a bubble inside a 3-beat packet of 1s.
    beat(1'b0, 4'h1); tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b1, fill(4'h5), fill(4'h5)); tick();
      chk("stall_valid", 32'(bu.o_valid), 32'd0);
      chk("stall_hold",  32'(bu.o_data),  32'd16);
    end
    drive(1'b1, 1'b0, 1'b1, fill(4'hF), fill(4'hF)); tick();
    beat(1'b0, 4'h1); tick();
    beat(1'b1, 4'h1); tick();
    idle();
    chk("stall_c7_valid", 32'(bu.o_valid), 32'd0);
    tick();
    chk("stall_c8_valid", 32'(bu.o_valid), 32'd1);
    chk("stall_c8_data",  32'(bu.o_data),  32'd24);
    drive(1'b0, 1'b0, 1'b0, fill(4'h0), fill(4'h0)); tick();
    chk("en_low_holds_pulse", 32'(bu.o_valid), 32'd1);
    idle(); tick();
    chk("pulse_drops", 32'(bu.o_valid), 32'd0);

    // Reset after the 2nd beat discards the packet.
    beat(1'b0, 4'h1); tick();
    beat(1'b0, 4'h1); tick();
    rst = 1'b1;
    beat(1'b1, 4'h1); tick();
    rst = 1'b0;
    idle();
    chk("midrst_valid", 32'(bu.o_valid), 32'd0);
    chk("midrst_data",  32'(bu.o_data),  32'd0);
    chk("midrst_ovf",   32'(bu.o_ovf),   32'd0);
    tick();
    chk("midrst_late_valid", 32'(bu.o_valid), 32'd0);
    beat(1'b1, 4'h3); tick();
    idle(); tick();
    chk("postrst_valid", 32'(bu.o_valid), 32'd1);
    chk("postrst_data",  32'(bu.o_data),  32'd24);

    // Signed operands: all -1, then +7 x4 / -8 x4, back to back.
    do_reset();
    drive(1'b1, 1'b1, 1'b1, fill(4'hF), fill(4'hF)); tick();
    drive(1'b1, 1'b1, 1'b1, fill(4'h0), mixed); tick();
    chk("sgn_neg1_valid", 32'(bs.o_valid), 32'd1);
    chk("sgn_neg1_data",  32'(bs.o_data),  32'h1FF8);
    chk("uns_same_data",  32'(bu.o_data),  32'd120);
    idle(); tick();
    chk("sgn_mix_valid", 32'(bs.o_valid), 32'd1);
    chk("sgn_mix_data",  32'(bs.o_data),  32'h1FFC);
    tick();
    chk("sgn_end_valid", 32'(bs.o_valid), 32'd0);

    // Overflow with ACCL2=1: 3-beat packet flags, following 2-beat packet does not.
    do_reset();
    beat(1'b0, 4'h1); tick();
    beat(1'b0, 4'h1); tick();
    beat(1'b1, 4'h1); tick();
    beat(1'b0, 4'h1); tick();
    chk("ovf3_valid", 32'(bo.o_valid), 32'd1);
    chk("ovf3_data",  32'(bo.o_data),  32'd24);
    chk("ovf3_ovf",   32'(bo.o_ovf),   32'd1);
    chk("wide_no_ovf", 32'(bu.o_ovf),  32'd0);
    beat(1'b1, 4'h1); tick();
    chk("ovf_gap_valid", 32'(bo.o_valid), 32'd0);
    idle(); tick();
    chk("ovf2_valid", 32'(bo.o_valid), 32'd1);
    chk("ovf2_data",  32'(bo.o_data),  32'd16);
    chk("ovf2_ovf",   32'(bo.o_ovf),   32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
